// File: rtl/pc_fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its PC, memory and execute unit.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface pc_fetch_sequencer_if #(
    parameter int AddrWidth = 8,
    parameter int DataWidth = 16
);
    logic                 start;
    logic                 halt;
    logic                 exec_done;
    logic                 branch;
    logic [AddrWidth-1:0] branch_addr;
    logic [DataWidth-1:0] mem_data;
    logic                 mem_ready;
    logic                 pc_load_n;
    logic                 pc_enable;
    logic                 pc_oe_n;
    logic [AddrWidth-1:0] pc_d;
    logic                 mem_read;
    logic [DataWidth-1:0] ir;
    logic                 ir_valid;
    logic                 busy;
    logic                 fault;
    logic [2:0]           state;

    modport master (
        input  start, halt, exec_done, branch, branch_addr, mem_data, mem_ready,
        output pc_load_n, pc_enable, pc_oe_n, pc_d, mem_read, ir, ir_valid, busy, fault, state
    );

    modport slave (
        output start, halt, exec_done, branch, branch_addr, mem_data, mem_ready,
        input  pc_load_n, pc_enable, pc_oe_n, pc_d, mem_read, ir, ir_valid, busy, fault, state
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch/branch controller for an external up-counter PC: strobes the counter and memory,
// latches instructions, reloads the PC on taken branches and parks on memory timeout.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset, waiting for start
//   ADDR   | PC drives the bus, read strobe issued, timeout armed
//   WAIT   | read strobe held until mem_ready or timeout
//   LATCH  | instruction captured, PC increments, ir_valid pulse
//   EXEC   | waiting for exec_done; picks halt / branch / next fetch
//   BRANCH | counter loads the registered branch target
//   HALTED | stopped between instructions, start resumes
//   FAULT  | memory timeout, left only through reset
module pc_fetch_sequencer #(
    parameter int AddrWidth   = 8,
    parameter int DataWidth   = 16,
    parameter int WaitTimeout = 15
) (
    input logic                  clk_i,
    input logic                  rst_i,
    pc_fetch_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WAIT   = 3'd2,
        S_LATCH  = 3'd3,
        S_EXEC   = 3'd4,
        S_BRANCH = 3'd5,
        S_HALTED = 3'd6,
        S_FAULT  = 3'd7
    } state_e;

    // Timeout is a down-counter: loaded in ADDR, fault when it hits zero without mem_ready.
    localparam logic [7:0] WaitLoad = 8'(WaitTimeout - 1);

    state_e               state_q, state_d;
    logic [DataWidth-1:0] ir_q, ir_d;
    logic [AddrWidth-1:0] pc_d_q, pc_d_d;
    logic                 fault_q, fault_d;
    logic [7:0]           wait_q, wait_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            pc_d_q  <= '0;
            fault_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_d_q  <= pc_d_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d_d  = pc_d_q;
        fault_d = fault_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_ADDR;
            end
            S_ADDR: begin
                wait_d  = WaitLoad;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_data;
                    state_d = S_LATCH;
                end else if (wait_q == 8'd0) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            S_LATCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Halt wins over a simultaneous branch; the branch target is dropped.
                if (bus.exec_done) begin
                    if (bus.halt) begin
                        state_d = S_HALTED;
                    end else if (bus.branch) begin
                        pc_d_d  = bus.branch_addr;
                        state_d = S_BRANCH;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_BRANCH: begin
                state_d = S_ADDR;
            end
            S_HALTED: begin
                if (bus.start) state_d = S_ADDR;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Load and enable live in different states, so the counter never sees both at once.
    assign bus.pc_load_n = (state_q != S_BRANCH);
    assign bus.pc_enable = (state_q == S_LATCH);
    assign bus.pc_oe_n   = !((state_q == S_ADDR) || (state_q == S_WAIT));
    assign bus.mem_read  = (state_q == S_ADDR) || (state_q == S_WAIT);
    assign bus.ir_valid  = (state_q == S_LATCH);
    assign bus.busy      = (state_q == S_ADDR) || (state_q == S_WAIT) || (state_q == S_LATCH) ||
                           (state_q == S_EXEC) || (state_q == S_BRANCH);
    assign bus.ir        = ir_q;
    assign bus.pc_d      = pc_d_q;
    assign bus.fault     = fault_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: a cycle model of the fetch rules plus a model of the external
// counter, checked every cycle, and directed scenarios with literal expectations.
module tb_pc_fetch_sequencer;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_sequencer_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    pc_fetch_sequencer #(.AddrWidth(AW), .DataWidth(DW), .WaitTimeout(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // External up-counter PC: enable overrides load.
    logic [AW-1:0] pc = '0;
    always @(posedge clk) begin
        if (rst)                pc <= '0;
        else if (bus.pc_enable) pc <= pc + 1'b1;
        else if (!bus.pc_load_n) pc <= bus.pc_d;
    end

    // Reference model of the fetch rules.
    int            m_state = 0;
    int            m_wait  = 0;
    logic [DW-1:0] m_ir    = '0;
    logic [AW-1:0] m_pcd   = '0;
    bit            m_fault = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_wait = 0; m_ir = '0; m_pcd = '0; m_fault = 1'b0;
        end else begin
            case (m_state)
                0: if (bus.start) m_state = 1;
                1: begin m_wait = 0; m_state = 2; end
                2: if (bus.mem_ready) begin
                       m_ir = bus.mem_data; m_state = 3;
                   end else if (m_wait == TO - 1) begin
                       m_fault = 1'b1; m_state = 7;
                   end else begin
                       m_wait++;
                   end
                3: m_state = 4;
                4: if (bus.exec_done) begin
                       if (bus.halt) m_state = 6;
                       else if (bus.branch) begin m_pcd = bus.branch_addr; m_state = 5; end
                       else m_state = 1;
                   end
                5: m_state = 1;
                6: if (bus.start) m_state = 1;
                default: m_state = 7;
            endcase
        end
    end

    bit run_cmp = 1'b0;
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("state",     32'(bus.state),     32'(m_state));
            chk("pc_load_n", 32'(bus.pc_load_n), 32'(m_state != 5));
            chk("pc_enable", 32'(bus.pc_enable), 32'(m_state == 3));
            chk("pc_oe_n",   32'(bus.pc_oe_n),   32'(!(m_state == 1 || m_state == 2)));
            chk("mem_read",  32'(bus.mem_read),  32'(m_state == 1 || m_state == 2));
            chk("ir_valid",  32'(bus.ir_valid),  32'(m_state == 3));
            chk("busy",      32'(bus.busy),      32'(m_state >= 1 && m_state <= 5));
            chk("ir",        32'(bus.ir),        32'(m_ir));
            chk("pc_d",      32'(bus.pc_d),      32'(m_pcd));
            chk("fault",     32'(bus.fault),     32'(m_fault));
            chk("load_and_enable", 32'(!bus.pc_load_n && bus.pc_enable), 32'(0));
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int seq [4] = '{1, 2, 3, 4};
    int ivc;
    int enc;

    initial begin
        bus.start = 0; bus.halt = 0; bus.exec_done = 0; bus.branch = 0;
        bus.branch_addr = '0; bus.mem_data = '0; bus.mem_ready = 0;
        step(2);
        run_cmp = 1'b1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_ir", 32'(bus.ir), 32'd0);
        chk("rst_strobes", {28'd0, bus.pc_load_n, bus.pc_enable, bus.pc_oe_n, bus.mem_read}, 32'b1010);
        rst = 1'b0;

        // Back-to-back sequential fetch
        bus.mem_ready = 1; bus.exec_done = 1; bus.mem_data = 16'h1234; bus.start = 1;
        step(1);
        bus.start = 0;
        ivc = 0;
        for (int i = 0; i < 12; i++) begin
            chk("seq_state", 32'(bus.state), 32'(seq[i % 4]));
            if (bus.ir_valid) ivc++;
            step(1);
        end
        chk("seq_irvalid_count", 32'(ivc), 32'd3);
        chk("seq_pc", 32'(pc), 32'd3);
        chk("seq_ir", 32'(bus.ir), 32'h1234);

        // Memory answers after three wait cycles
        bus.mem_ready = 0; bus.mem_data = 16'hA55A;
        step(1);
        enc = 0;
        for (int i = 0; i < 3; i++) begin
            chk("wait_hold", {29'd0, bus.state}, 32'd2);
            chk("wait_strobes", {30'd0, bus.mem_read, bus.pc_oe_n}, 32'b10);
            if (bus.pc_enable) enc++;
            step(1);
        end
        chk("wait4_state", 32'(bus.state), 32'd2);
        bus.mem_ready = 1; bus.exec_done = 0;
        step(1);
        chk("latch_ir", 32'(bus.ir), 32'hA55A);
        if (bus.pc_enable) enc++;
        step(1);
        chk("wait_enable_pulses", 32'(enc), 32'd1);
        chk("wait_pc", 32'(pc), 32'd4);

        // Taken branch to 0x3C
        step(2);
        chk("exec_stall", 32'(bus.state), 32'd4);
        bus.exec_done = 1; bus.branch = 1; bus.branch_addr = 8'h3C;
        step(1);
        bus.branch = 0;
        chk("branch_state", 32'(bus.state), 32'd5);
        chk("branch_pcd", 32'(bus.pc_d), 32'h3C);
        chk("branch_load_n", 32'(bus.pc_load_n), 32'd0);
        step(1);
        chk("branch_addr_state", 32'(bus.state), 32'd1);
        chk("branch_addr_pc", 32'(pc), 32'h3C);

        // Halt beats a simultaneous branch
        step(3);
        chk("halt_in_exec", 32'(bus.state), 32'd4);
        bus.halt = 1; bus.branch = 1; bus.branch_addr = 8'h77;
        step(1);
        bus.halt = 0; bus.branch = 0;
        chk("halted_state", 32'(bus.state), 32'd6);
        chk("halted_pcd", 32'(bus.pc_d), 32'h3C);
        step(2);
        chk("halted_pc", 32'(pc), 32'h3D);
        bus.start = 1;
        step(1);
        bus.start = 0;
        chk("resume_state", 32'(bus.state), 32'd1);
        chk("resume_pc", 32'(pc), 32'h3D);

        // Memory timeout
        bus.mem_ready = 0;
        step(1);
        for (int i = 0; i < TO; i++) begin
            chk("timeout_wait", 32'(bus.state), 32'd2);
            step(1);
        end
        chk("fault_state", 32'(bus.state), 32'd7);
        chk("fault_flag", 32'(bus.fault), 32'd1);
        bus.start = 1;
        step(2);
        bus.start = 0;
        chk("fault_sticky", 32'(bus.state), 32'd7);
        rst = 1;
        step(1);
        rst = 0;
        chk("fault_clear_state", 32'(bus.state), 32'd0);
        chk("fault_clear_flag", 32'(bus.fault), 32'd0);

        // Reset during WAIT
        bus.start = 1;
        step(1);
        bus.start = 0;
        step(1);
        chk("pre_rst_wait", 32'(bus.state), 32'd2);
        rst = 1;
        step(1);
        rst = 0;
        chk("rst_wait_state", 32'(bus.state), 32'd0);
        chk("rst_wait_read", 32'(bus.mem_read), 32'd0);

        // Reset during BRANCH
        bus.mem_ready = 1; bus.exec_done = 1; bus.branch = 1; bus.branch_addr = 8'h55; bus.start = 1;
        step(1);
        bus.start = 0;
        step(4);
        chk("pre_rst_branch", 32'(bus.state), 32'd5);
        rst = 1;
        step(1);
        rst = 0;
        bus.branch = 0;
        chk("rst_branch_state", 32'(bus.state), 32'd0);
        chk("rst_branch_load_n", 32'(bus.pc_load_n), 32'd1);
        chk("rst_branch_irvalid", 32'(bus.ir_valid), 32'd0);
        step(2);

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
